// File: rtl/adder_pkg.sv
// Shared adder-library package: accumulator FSM states and default widths.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : adder_pkg

// File: rtl/cs_adder.sv
// Combinational ripple-carry adder: Sum_o = A_i + B_i + Carry_i, carry-out on Carry_o.
module cs_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Carry_i,
  output logic [WIDTH-1:0] Sum_o,
  output logic             Carry_o
);

  logic [WIDTH:0] carry;

  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // or loop touches it, so no latch can be inferred.
    carry    = '0;
    Sum_o    = '0;
    carry[0] = Carry_i;
    for (int i = 0; i < WIDTH; i++) begin
      Sum_o[i]     = A_i[i] ^ B_i[i] ^ carry[i];
      carry[i + 1] = (A_i[i] & B_i[i]) | (carry[i] & (A_i[i] ^ B_i[i]));
    end
  end

  assign Carry_o = carry[WIDTH];

endmodule : cs_adder

// File: rtl/add_accumulator.sv
// Multi-operand accumulator: sums Len_i streamed operands; exact sum is
// {CarryCnt_o, Result_o}, with a one-cycle Done_o at the end of each run.
module add_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Start_i,
  input  logic [CNT_W-1:0] Len_i,
  input  logic [WIDTH-1:0] Operand_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  output logic [WIDTH-1:0] Result_o,
  output logic [CNT_W-1:0] CarryCnt_o,
  output logic             Busy_o,
  output logic             Done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [WIDTH-1:0] sum;
  logic             sum_carry;

  cs_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A_i     (acc_q),
    .B_i     (Operand_i),
    .Carry_i (1'b0),
    .Sum_o   (sum),
    .Carry_o (sum_carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    remaining_d = remaining_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          acc_d       = '0;
          carry_cnt_d = '0;
          remaining_d = Len_i;
          state_d     = (Len_i == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Ready_o is high throughout ACCUM, so Valid_i alone marks a transfer.
        if (Valid_i) begin
          acc_d       = sum;
          carry_cnt_d = carry_cnt_q + {{(CNT_W-1){1'b0}}, sum_carry};
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      carry_cnt_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      remaining_q <= remaining_d;
    end
  end

  assign Ready_o    = (state_q == ST_ACCUM);
  assign Busy_o     = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign Done_o     = (state_q == ST_DONE);
  assign Result_o   = acc_q;
  assign CarryCnt_o = carry_cnt_q;

endmodule : add_accumulator

// File: tb/tb_add_accumulator.sv
// Scoreboard bench for add_accumulator: runs push hand-computed final sums and
// Done_o cycles; a negedge monitor pops and compares whenever Done_o is seen.
module tb_add_accumulator;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] operand;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] carry_cnt;
  logic             busy;
  logic             done;

  add_accumulator #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk_i      (clk),
    .Rst_i      (rst),
    .Start_i    (start),
    .Len_i      (len),
    .Operand_i  (operand),
    .Valid_i    (valid),
    .Ready_o    (ready),
    .Result_o   (result),
    .CarryCnt_o (carry_cnt),
    .Busy_o     (busy),
    .Done_o     (done)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cc;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every Done_o pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: Done_o high with no run outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_result", 64'(result), 64'(e.res));
        check("done_carry",  64'(carry_cnt), 64'(e.cc));
        check("done_cycle",  64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One run: gap idle cycles follow the first operand; mid_start asserts
  // Start_i (Len_i=9) alongside the second operand.
  task automatic run(input int unsigned n, input logic [WIDTH-1:0] ops [4],
                     input int gap, input bit mid_start,
                     input logic [WIDTH-1:0] exp_res, input logic [CNT_W-1:0] exp_cc);
    exp_t e;
    int   s;
    step();
    s     = cyc + 1;
    e.res = exp_res;
    e.cc  = exp_cc;
    e.cyc = s + int'(n) + gap;
    sb.push_back(e);
    start = 1'b1;
    len   = CNT_W'(n);
    step();
    start = 1'b0;
    len   = '0;
    @(negedge clk);
    check("ready_after_start", 64'(ready), 64'(n != 0));
    check("busy_after_start",  64'(busy), 64'd1);
    for (int i = 0; i < int'(n); i++) begin
      valid   = 1'b1;
      operand = ops[i];
      if (mid_start && i == 1) begin
        start = 1'b1;
        len   = 8'd9;
      end
      step();
      valid   = 1'b0;
      operand = '0;
      start   = 1'b0;
      len     = '0;
      if (i == 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("hold_in_stall", 64'(result), 64'(ops[0]));
          step();
        end
      end
    end
    step();
    step();
    @(negedge clk);
    check("idle_busy",   64'(busy), 64'd0);
    check("idle_ready",  64'(ready), 64'd0);
    check("idle_result", 64'(result), 64'(exp_res));
    check("idle_carry",  64'(carry_cnt), 64'(exp_cc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    len     = '0;
    operand = '0;
    valid   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  64'(ready), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry",  64'(carry_cnt), 64'd0);

    // Basic run: 5 + 7 + 9.
    run(3, '{32'd5, 32'd7, 32'd9, 32'd0}, 0, 1'b0, 32'd21, 8'd0);
    // Carry counting: 3 * 0xFFFFFFFF = 0x2_FFFFFFFD.
    run(3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}, 0, 1'b0,
        32'hFFFF_FFFD, 8'd2);
    // Stalls: three idle cycles between 0x10 and 0x20.
    run(2, '{32'h10, 32'h20, 32'd0, 32'd0}, 3, 1'b0, 32'h30, 8'd0);
    // Zero length.
    run(0, '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 1'b0, 32'd0, 8'd0);
    // Start_i during ACCUM is ignored.
    run(4, '{32'd1, 32'd2, 32'd3, 32'd4}, 0, 1'b1, 32'd10, 8'd0);

    // Reset after two of four operands: no Done_o, everything back to 0.
    step();
    start = 1'b1;
    len   = 8'd4;
    step();
    start   = 1'b0;
    len     = '0;
    valid   = 1'b1;
    operand = 32'h100;
    step();
    operand = 32'h200;
    step();
    valid   = 1'b0;
    operand = '0;
    @(negedge clk);
    check("midrun_partial", 64'(result), 64'h300);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready",  64'(ready), 64'd0);
    check("abort_busy",   64'(busy), 64'd0);
    check("abort_done",   64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_carry",  64'(carry_cnt), 64'd0);
    repeat (3) step();

    // Recovery run after the abort.
    run(1, '{32'h55, 32'd0, 32'd0, 32'd0}, 0, 1'b0, 32'h55, 8'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_add_accumulator
